// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC/IF_ID/ID_EX enables, flush and bubbles,
// load-use detection and the mult/div busy sequencer that guards HI/LO consumers.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_md_start,
  input  logic              id_md_div,
  input  logic              id_uses_hilo,
  input  logic              ex_memr,
  input  logic [4:0]        ex_rd,
  input  logic              ex_redirect,
  output logic              pc_wr_en,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              md_issue,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} md_state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu, mdh, stall, issue;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Hazard detection and pipeline control for the current cycle; everything is
  // held inactive while rst is asserted.
  always_comb begin
    lu    = ex_memr && (ex_rd != 5'd0) &&
            ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    mdh   = busy_q && !done_q && (id_uses_hilo || id_md_start);
    stall = !ex_redirect && (mdh || lu);
    // mdh already covers a start arriving while the unit is still occupied.
    issue = rst && id_md_start && !ex_redirect && !lu && !mdh;

    pc_wr_en     = rst && !stall;
    if_id_wr     = rst && !stall;
    if_id_flush  = rst && ex_redirect;
    id_ex_bubble = rst && (ex_redirect || stall);
    md_issue     = issue;
    md_busy      = busy_q;
    md_done      = done_q;
    stall_cnt    = stall_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_BUSY;
          cnt_d   = id_md_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          // Final cycle: a waiting start reloads without an idle gap.
          if (issue) begin
            cnt_d = id_md_div ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d      = (state_d == S_BUSY);
    done_d      = busy_d && (cnt_d == '0);
    stall_cnt_d = pc_wr_en ? stall_cnt_q : sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push expected
// control outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_uses_rt = 0, id_md_start = 0, id_md_div = 0, id_uses_hilo = 0;
  logic        ex_memr = 0, ex_redirect = 0;
  logic        pc_wr_en, if_id_wr, if_id_flush, id_ex_bubble;
  logic        md_issue, md_busy, md_done;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_div(id_md_div), .id_uses_hilo(id_uses_hilo),
    .ex_memr(ex_memr), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_wr_en(pc_wr_en), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .md_issue(md_issue), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  ctl;   // {pc_wr_en, if_id_wr, if_id_flush, id_ex_bubble}
    logic [2:0]  md;    // {md_issue, md_busy, md_done}
    logic [15:0] scnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        rst_v = 1'b0;
  logic [15:0] exp_scnt = '0;

  localparam logic [3:0] ADV = 4'b1100, STL = 4'b0001, RDR = 4'b1111, OFF = 4'b0000;

  // One cycle of stimulus; expected outputs are the hand-derived values passed in.
  task automatic vec(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic st, input logic dv, input logic hl,
                     input logic mr, input logic [4:0] rd, input logic rdr,
                     input logic [3:0] ctl, input logic [2:0] md);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_md_start = st;
    id_md_div = dv; id_uses_hilo = hl; ex_memr = mr; ex_rd = rd; ex_redirect = rdr;
    if (!rst_v) exp_scnt = '0;
    e.nm = nm; e.ctl = ctl; e.md = md; e.scnt = exp_scnt;
    sb.push_back(e);
    if (rst_v && !ctl[3]) exp_scnt = exp_scnt + 1'b1;
  endtask

  task automatic adv(input string nm, input logic [2:0] md);
    vec(nm, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ADV, md);
  endtask

  task automatic mstart(input string nm, input logic dv, input logic [3:0] ctl,
                        input logic [2:0] md);
    vec(nm, 5'd8, 5'd9, 1'b1, 1'b1, dv, 1'b0, 1'b0, 5'd0, 1'b0, ctl, md);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({pc_wr_en, if_id_wr, if_id_flush, id_ex_bubble} !== e.ctl ||
          {md_issue, md_busy, md_done} !== e.md || stall_cnt !== e.scnt) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b md=%b scnt=%0d, want ctl=%b md=%b scnt=%0d",
                 e.nm, {pc_wr_en, if_id_wr, if_id_flush, id_ex_bubble},
                 {md_issue, md_busy, md_done}, stall_cnt, e.ctl, e.md, e.scnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset holds everything low even with hazards and a start present.
    rst_v = 1'b0;
    vec("rst_a", 5'd2, 5'd4, 1, 1, 0, 0, 1, 5'd2, 0, OFF, 3'b000);
    vec("rst_b", 5'd2, 5'd4, 1, 1, 0, 1, 1, 5'd2, 1, OFF, 3'b000);
    rst_v = 1'b1;
    adv("post_rst", 3'b000);

    // Load-use on rs, on rt, rt unused, and ex_rd==0.
    vec("lu_rs",   5'd2, 5'd4, 1, 0, 0, 0, 1, 5'd2, 0, STL, 3'b000);
    vec("lu_rel",  5'd2, 5'd4, 1, 0, 0, 0, 0, 5'd0, 0, ADV, 3'b000);
    vec("lu_rt",   5'd5, 5'd7, 1, 0, 0, 0, 1, 5'd7, 0, STL, 3'b000);
    vec("rt_unus", 5'd5, 5'd7, 0, 0, 0, 0, 1, 5'd7, 0, ADV, 3'b000);
    vec("rd_zero", 5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0, ADV, 3'b000);

    // mult then mflo: 3 stall cycles, released in the done cycle.
    mstart("mul_iss", 0, ADV, 3'b100);
    for (int i = 0; i < 3; i++)
      vec("mflo_stl", 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, STL, 3'b010);
    vec("mflo_go", 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, ADV, 3'b011);
    adv("mul_idle", 3'b000);

    // div with independent work, redirect mid-flight keeps it busy,
    // and a mult issued in the done cycle reloads without a gap.
    mstart("div_iss", 1, ADV, 3'b100);
    for (int i = 1; i < 32; i++) begin
      if (i == 10) vec("div_rdr", 5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 1, RDR, 3'b010);
      else         adv("div_run", 3'b010);
    end
    mstart("b2b_iss", 0, ADV, 3'b111);
    // A second mult waits in ID while the unit is occupied.
    for (int i = 0; i < 3; i++) mstart("md_wait", 0, STL, 3'b010);
    mstart("md_reiss", 0, ADV, 3'b111);
    for (int i = 0; i < 3; i++) adv("mul2_run", 3'b010);
    adv("mul2_done", 3'b011);
    adv("mul2_idle", 3'b000);

    // Redirect beats load-use and squashes the start; load-use blocks issue.
    vec("rdr_lu_md", 5'd2, 5'd3, 1, 1, 0, 0, 1, 5'd2, 1, RDR, 3'b000);
    vec("lu_blk_md", 5'd2, 5'd3, 1, 1, 0, 0, 1, 5'd2, 0, STL, 3'b000);
    mstart("lu_gone", 0, ADV, 3'b100);
    for (int i = 0; i < 3; i++) adv("mul3_run", 3'b010);
    adv("mul3_done", 3'b011);

    // Reset in the middle of a div, then a clean restart.
    mstart("div2_iss", 1, ADV, 3'b100);
    for (int i = 0; i < 21; i++) adv("div2_run", 3'b010);
    rst_v = 1'b0;
    vec("rst_busy", 5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 0, OFF, 3'b000);
    vec("rst_hold", 5'd2, 5'd2, 1, 1, 0, 0, 1, 5'd2, 0, OFF, 3'b000);
    rst_v = 1'b1;
    adv("restart", 3'b000);
    vec("re_lu", 5'd2, 5'd4, 1, 0, 0, 0, 1, 5'd2, 0, STL, 3'b000);
    mstart("re_iss", 0, ADV, 3'b100);
    for (int i = 0; i < 3; i++) adv("re_run", 3'b010);
    adv("re_done", 3'b011);
    adv("re_idle", 3'b000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
